// File: rtl/clct_hold_dispatch.sv
// clct_hold_dispatch
// Takes the per-bx best CFEB 1/2-strip candidate and qualifies it against a hit
// threshold. It holds the candidate for a drift window, during which better-ranked
// candidates replace it. The winner, tagged with the bx of its first latch, is then
// offered on a valid/ready port. A dead time follows each dispatch, and qualifying
// candidates that arrive while the block is busy are counted as drops.
module clct_hold_dispatch #(
    parameter int MXPIDB  = 4,
    parameter int MXHITB  = 3,
    parameter int MXPATB  = 7,
    parameter int MXKEYB  = 5,
    parameter int MXKEYBX = 8,
    parameter int MXBXN   = 12,
    parameter int BXN_MAX = 3563
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cand_vld,
    input  logic [MXPATB-1:0]           cand_pat,
    input  logic [MXKEYBX-1:0]          cand_key,
    input  logic [MXHITB-1:0]           hit_thresh,
    input  logic [3:0]                  drift_dly,
    input  logic [3:0]                  dead_time,
    input  logic                        out_rdy,
    output logic                        out_vld,
    output logic [MXPATB-1:0]           out_pat,
    output logic                        out_bend,
    output logic [MXKEYBX-MXKEYB-1:0]   out_cfeb,
    output logic [MXKEYB-1:0]           out_key,
    output logic [MXKEYBX-1:0]          out_hs,
    output logic [MXBXN-1:0]            out_bxn,
    output logic [7:0]                  drop_cnt,
    output logic                        err_cfeb
);

    localparam int                 CFEBB     = MXKEYBX - MXKEYB;
    localparam logic [CFEBB-1:0]   CFEB_LAST = CFEBB'(4);
    localparam logic [MXBXN-1:0]   BXN_LAST  = MXBXN'(BXN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SEND = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    // Rank ignores the bend bit in the lsb; only a strictly better rank wins.
    function automatic logic rank_gt(input logic [MXPATB-1:0] a_pat,
                                     input logic [MXPATB-1:0] b_pat);
        return (a_pat[MXPATB-1:1] > b_pat[MXPATB-1:1]);
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [MXBXN-1:0]     bxn_r;
    logic [MXPATB-1:0]    held_pat_r;
    logic [MXKEYBX-1:0]   held_key_r;
    logic [MXBXN-1:0]     held_bxn_r;
    logic [3:0]           hold_cnt_r;
    logic [3:0]           dead_cnt_r;

    logic                 out_vld_r;
    logic [MXPATB-1:0]    out_pat_r;
    logic [MXKEYBX-1:0]   out_hs_r;
    logic [MXBXN-1:0]     out_bxn_r;
    logic [7:0]           drop_cnt_r;
    logic                 err_cfeb_r;

    logic                 cfeb_bad_s;
    logic                 qualify_s;
    logic                 latch_s;
    logic                 replace_s;
    logic                 drop_s;
    logic                 handshake_s;
    logic                 load_out_s;
    logic [MXPATB-1:0]    win_pat_s;
    logic [MXKEYBX-1:0]   win_key_s;
    logic [MXBXN-1:0]     win_bxn_s;

    // Candidate qualification: hit threshold and a legal CFEB number (0..4).
    always_comb begin
        cfeb_bad_s = 1'b0;
        qualify_s  = 1'b0;
        if (cand_vld) begin
            cfeb_bad_s = (cand_key[MXKEYBX-1:MXKEYB] > CFEB_LAST);
            qualify_s  = !cfeb_bad_s && (cand_pat[MXPATB-1:MXPIDB] >= hit_thresh);
        end else begin
            cfeb_bad_s = 1'b0;
            qualify_s  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (qualify_s) begin
                    state_nxt_s = (drift_dly == 4'd0) ? ST_SEND : ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r <= 4'd1) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_SEND: begin
                if (out_rdy) begin
                    state_nxt_s = (dead_time == 4'd0) ? ST_IDLE : ST_DEAD;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DEAD: begin
                if (dead_cnt_r <= 4'd1) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DEAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM control decode and selection of the candidate that wins this bx.
    always_comb begin
        latch_s     = (state_r == ST_IDLE) && qualify_s;
        replace_s   = (state_r == ST_HOLD) && qualify_s && rank_gt(cand_pat, held_pat_r);
        drop_s      = ((state_r == ST_SEND) || (state_r == ST_DEAD)) && qualify_s;
        handshake_s = (state_r == ST_SEND) && out_rdy;
        load_out_s  = (state_nxt_s == ST_SEND) && (state_r != ST_SEND);
        win_pat_s   = held_pat_r;
        win_key_s   = held_key_r;
        win_bxn_s   = held_bxn_r;
        if (latch_s) begin
            win_pat_s = cand_pat;
            win_key_s = cand_key;
            win_bxn_s = bxn_r;
        end else if (replace_s) begin
            // A replacement keeps the bx of the first latch.
            win_pat_s = cand_pat;
            win_key_s = cand_key;
            win_bxn_s = held_bxn_r;
        end else begin
            win_pat_s = held_pat_r;
            win_key_s = held_key_r;
            win_bxn_s = held_bxn_r;
        end
    end

    // Free-running bx counter and the held candidate registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            bxn_r      <= '0;
            held_pat_r <= '0;
            held_key_r <= '0;
            held_bxn_r <= '0;
        end else begin
            bxn_r      <= (bxn_r == BXN_LAST) ? '0 : bxn_r + MXBXN'(1);
            held_pat_r <= win_pat_s;
            held_key_r <= win_key_s;
            held_bxn_r <= win_bxn_s;
        end
    end

    // Drift-window and dead-time down counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_r <= 4'd0;
            dead_cnt_r <= 4'd0;
        end else begin
            if (latch_s) begin
                hold_cnt_r <= drift_dly;
            end else if ((state_r == ST_HOLD) && (hold_cnt_r != 4'd0)) begin
                hold_cnt_r <= hold_cnt_r - 4'd1;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
            if (handshake_s) begin
                dead_cnt_r <= dead_time;
            end else if ((state_r == ST_DEAD) && (dead_cnt_r != 4'd0)) begin
                dead_cnt_r <= dead_cnt_r - 4'd1;
            end else begin
                dead_cnt_r <= dead_cnt_r;
            end
        end
    end

    // Registered outputs: dispatch data is captured on entry to SEND and held after.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_vld_r  <= 1'b0;
            out_pat_r  <= '0;
            out_hs_r   <= '0;
            out_bxn_r  <= '0;
            drop_cnt_r <= 8'd0;
            err_cfeb_r <= 1'b0;
        end else begin
            out_vld_r  <= (state_nxt_s == ST_SEND);
            err_cfeb_r <= err_cfeb_r | cfeb_bad_s;
            if (load_out_s) begin
                out_pat_r <= win_pat_s;
                out_hs_r  <= win_key_s;
                out_bxn_r <= win_bxn_s;
            end else begin
                out_pat_r <= out_pat_r;
                out_hs_r  <= out_hs_r;
                out_bxn_r <= out_bxn_r;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign out_vld  = out_vld_r;
    assign out_pat  = out_pat_r;
    assign out_bend = out_pat_r[0];
    assign out_hs   = out_hs_r;
    assign out_cfeb = out_hs_r[MXKEYBX-1:MXKEYB];
    assign out_key  = out_hs_r[MXKEYB-1:0];
    assign out_bxn  = out_bxn_r;
    assign drop_cnt = drop_cnt_r;
    assign err_cfeb = err_cfeb_r;

endmodule

// File: tb/tb_clct_hold_dispatch.sv
// Testbench for clct_hold_dispatch: directed scenarios plus a random run checked
// against a timestamp-based behavioural model of the hold/dispatch rules.
module tb_clct_hold_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        cand_vld;
    logic [6:0]  cand_pat;
    logic [7:0]  cand_key;
    logic [2:0]  hit_thresh;
    logic [3:0]  drift_dly;
    logic [3:0]  dead_time;
    logic        out_rdy;
    logic        out_vld;
    logic [6:0]  out_pat;
    logic        out_bend;
    logic [2:0]  out_cfeb;
    logic [4:0]  out_key;
    logic [7:0]  out_hs;
    logic [11:0] out_bxn;
    logic [7:0]  drop_cnt;
    logic        err_cfeb;

    int errors = 0;
    int checks = 0;

    // Reference model: time-stamped view of the dispatch rules.
    int          m_cyc = 0;
    int          m_cool_end = -1;
    bit          m_collect = 1'b0;
    int          m_collect_end = 0;
    int          m_bxn = 0;
    bit          m_err = 1'b0;
    int          m_drop = 0;
    bit          m_vld = 1'b0;
    logic [6:0]  m_pat = '0;
    logic [7:0]  m_hs = '0;
    int          m_obxn = 0;
    logic [6:0]  b_pat = '0;
    logic [7:0]  b_key = '0;
    int          b_bxn = 0;

    clct_hold_dispatch dut (
        .clock(clock), .reset(reset), .cand_vld(cand_vld), .cand_pat(cand_pat),
        .cand_key(cand_key), .hit_thresh(hit_thresh), .drift_dly(drift_dly),
        .dead_time(dead_time), .out_rdy(out_rdy), .out_vld(out_vld), .out_pat(out_pat),
        .out_bend(out_bend), .out_cfeb(out_cfeb), .out_key(out_key), .out_hs(out_hs),
        .out_bxn(out_bxn), .drop_cnt(drop_cnt), .err_cfeb(err_cfeb)
    );

    always #5 clock = ~clock;

    task automatic model_dispatch();
        m_vld  = 1'b1;
        m_pat  = b_pat;
        m_hs   = b_key;
        m_obxn = b_bxn;
    endtask

    task automatic model_step();
        bit q;
        int hits;
        int cf;
        hits = int'(cand_pat[6:4]);
        cf   = int'(cand_key[7:5]);
        q    = cand_vld && (hits >= int'(hit_thresh)) && (cf <= 4);
        m_cyc++;
        if (reset) begin
            m_cool_end = -1; m_collect = 1'b0; m_bxn = 0; m_err = 1'b0; m_drop = 0;
            m_vld = 1'b0; m_pat = '0; m_hs = '0; m_obxn = 0;
            b_pat = '0; b_key = '0; b_bxn = 0;
        end else begin
            if (cand_vld && cf > 4) m_err = 1'b1;
            if (m_vld) begin
                if (q && m_drop < 255) m_drop++;
                if (out_rdy) begin
                    m_vld = 1'b0;
                    m_cool_end = m_cyc + int'(dead_time);
                end
            end else if (m_collect) begin
                if (q && (cand_pat[6:1] > b_pat[6:1])) begin
                    b_pat = cand_pat;
                    b_key = cand_key;
                end
                if (m_cyc == m_collect_end) begin
                    m_collect = 1'b0;
                    model_dispatch();
                end
            end else if (m_cyc <= m_cool_end) begin
                if (q && m_drop < 255) m_drop++;
            end else if (q) begin
                b_pat = cand_pat;
                b_key = cand_key;
                b_bxn = m_bxn;
                if (drift_dly == 4'd0) begin
                    model_dispatch();
                end else begin
                    m_collect = 1'b1;
                    m_collect_end = m_cyc + int'(drift_dly);
                end
            end
            m_bxn = (m_bxn == 3563) ? 0 : m_bxn + 1;
        end
    endtask

    // One bx: model sees the same inputs the DUT samples; return on the falling edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic set_cand(input logic v, input logic [6:0] p, input logic [7:0] k);
        cand_vld = v;
        cand_pat = p;
        cand_key = k;
    endtask

    task automatic test_reset();
        reset = 1'b1; set_cand(1'b0, 7'h00, 8'h00);
        hit_thresh = 3'd4; drift_dly = 4'd2; dead_time = 4'd0; out_rdy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", out_vld); end
        checks++; if (out_pat !== 7'h00) begin errors++; $display("FAIL reset_pat got=%h exp=00", out_pat); end
        checks++; if (out_hs !== 8'h00) begin errors++; $display("FAIL reset_hs got=%h exp=00", out_hs); end
        checks++; if (out_bxn !== 12'd0) begin errors++; $display("FAIL reset_bxn got=%0d exp=0", out_bxn); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++; if (err_cfeb !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err_cfeb); end
    endtask

    task automatic test_basic();
        int n;
        hit_thresh = 3'd4; drift_dly = 4'd2; dead_time = 4'd0; out_rdy = 1'b0;
        n = 0;
        while (m_bxn != 10 && n < 4000) begin tick(); n++; end
        checks++; if (m_bxn != 10) begin errors++; $display("FAIL basic_wait_bx got=%0d exp=10", m_bxn); end
        set_cand(1'b1, 7'h5A, 8'h45); tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_e1 got=%0b exp=0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_e2 got=%0b exp=0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL basic_vld_rise got=%0b exp=1", out_vld); end
        checks++; if (out_pat !== 7'h5A) begin errors++; $display("FAIL basic_pat got=%h exp=5a", out_pat); end
        checks++; if (out_cfeb !== 3'd2) begin errors++; $display("FAIL basic_cfeb got=%0d exp=2", out_cfeb); end
        checks++; if (out_key !== 5'd5) begin errors++; $display("FAIL basic_key got=%0d exp=5", out_key); end
        checks++; if (out_hs !== 8'h45) begin errors++; $display("FAIL basic_hs got=%h exp=45", out_hs); end
        checks++; if (out_bend !== 1'b0) begin errors++; $display("FAIL basic_bend got=%0b exp=0", out_bend); end
        checks++; if (out_bxn !== 12'd10) begin errors++; $display("FAIL basic_bxn got=%0d exp=10", out_bxn); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_fall got=%0b exp=0", out_vld); end
        checks++; if (out_hs !== 8'h45) begin errors++; $display("FAIL basic_hs_held got=%h exp=45", out_hs); end
    endtask

    task automatic test_replace();
        int bx0;
        hit_thresh = 3'd4; drift_dly = 4'd3; dead_time = 4'd0; out_rdy = 1'b0;
        bx0 = m_bxn;
        set_cand(1'b1, 7'h5A, 8'h45); tick();
        set_cand(1'b1, 7'h6A, 8'h81); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL repl_vld_early got=%0b exp=0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL repl_vld got=%0b exp=1", out_vld); end
        checks++; if (out_pat !== 7'h6A) begin errors++; $display("FAIL repl_pat got=%h exp=6a", out_pat); end
        checks++; if (out_hs !== 8'h81) begin errors++; $display("FAIL repl_hs got=%h exp=81", out_hs); end
        checks++; if (int'(out_bxn) != bx0) begin errors++; $display("FAIL repl_bxn got=%0d exp=%0d", out_bxn, bx0); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        set_cand(1'b1, 7'h5A, 8'h23); tick();
        set_cand(1'b1, 7'h5B, 8'h64); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick(); tick();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL tie_vld got=%0b exp=1", out_vld); end
        checks++; if (out_pat !== 7'h5A) begin errors++; $display("FAIL tie_pat got=%h exp=5a", out_pat); end
        checks++; if (out_hs !== 8'h23) begin errors++; $display("FAIL tie_hs got=%h exp=23", out_hs); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    endtask

    task automatic test_reject();
        hit_thresh = 3'd4; drift_dly = 4'd1; dead_time = 4'd0; out_rdy = 1'b0;
        set_cand(1'b1, 7'h3A, 8'h12); tick();
        set_cand(1'b0, 7'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL lowhit_vld i=%0d got=%0b exp=0", i, out_vld); end
        end
        checks++; if (err_cfeb !== 1'b0) begin errors++; $display("FAIL err_before got=%0b exp=0", err_cfeb); end
        set_cand(1'b1, 7'h7A, 8'hA3); tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (err_cfeb !== 1'b1) begin errors++; $display("FAIL err_cfeb got=%0b exp=1", err_cfeb); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL badcfeb_vld i=%0d got=%0b exp=0", i, out_vld); end
        end
        set_cand(1'b1, 7'h4C, 8'h10); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        checks++; if (out_vld !== 1'b1 || out_pat !== 7'h4C) begin
            errors++; $display("FAIL after_reject vld=%0b pat=%h exp vld=1 pat=4c", out_vld, out_pat);
        end
        checks++; if (err_cfeb !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp=1", err_cfeb); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    endtask

    task automatic test_stall();
        reset = 1'b1; tick(); reset = 1'b0;
        hit_thresh = 3'd4; drift_dly = 4'd1; dead_time = 4'd3; out_rdy = 1'b0;
        set_cand(1'b1, 7'h5A, 8'h45); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8) set_cand(1'b1, 7'h7E, 8'h20);
            else set_cand(1'b0, 7'h00, 8'h00);
            tick();
            checks++; if (out_vld !== 1'b1 || out_pat !== 7'h5A || out_hs !== 8'h45) begin
                errors++; $display("FAIL stall_stable i=%0d vld=%0b pat=%h hs=%h exp 1/5a/45", i, out_vld, out_pat, out_hs);
            end
        end
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL stall_drop got=%0d exp=3", drop_cnt); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL hs_vld_fall got=%0b exp=0", out_vld); end
        tick();
        set_cand(1'b1, 7'h6C, 8'h11); tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (drop_cnt !== 8'd4) begin errors++; $display("FAIL dead_drop got=%0d exp=4", drop_cnt); end
        set_cand(1'b1, 7'h7C, 8'h33); tick();
        checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL dead_last_drop got=%0d exp=5", drop_cnt); end
        tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL relatch_hold got=%0b exp=0", out_vld); end
        tick();
        checks++; if (out_vld !== 1'b1 || out_pat !== 7'h7C) begin
            errors++; $display("FAIL relatch vld=%0b pat=%h exp vld=1 pat=7c", out_vld, out_pat);
        end
        checks++; if (drop_cnt !== 8'd5) begin errors++; $display("FAIL relatch_drop got=%0d exp=5", drop_cnt); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    endtask

    task automatic test_drift0_reset();
        hit_thresh = 3'd4; drift_dly = 4'd0; dead_time = 4'd0; out_rdy = 1'b0;
        tick(); tick(); tick();
        set_cand(1'b1, 7'h5C, 8'h02); tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (out_vld !== 1'b1 || out_pat !== 7'h5C || out_hs !== 8'h02) begin
            errors++; $display("FAIL drift0 vld=%0b pat=%h hs=%h exp 1/5c/02", out_vld, out_pat, out_hs);
        end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        drift_dly = 4'd5;
        set_cand(1'b1, 7'h6A, 8'h33); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (out_vld !== 1'b0 || out_pat !== 7'h00 || out_hs !== 8'h00 || out_bxn !== 12'd0 ||
                      drop_cnt !== 8'd0 || err_cfeb !== 1'b0) begin
            errors++; $display("FAIL hold_reset vld=%0b pat=%h hs=%h bxn=%0d drop=%0d err=%0b exp all 0",
                               out_vld, out_pat, out_hs, out_bxn, drop_cnt, err_cfeb);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld i=%0d got=%0b exp=0", i, out_vld); end
        end
    endtask

    task automatic test_bx_wrap();
        int n;
        hit_thresh = 3'd4; drift_dly = 4'd1; dead_time = 4'd0; out_rdy = 1'b0;
        n = 0;
        while (m_bxn != 3563 && n < 4000) begin tick(); n++; end
        checks++; if (m_bxn != 3563) begin errors++; $display("FAIL wrap_wait got=%0d exp=3563", m_bxn); end
        set_cand(1'b1, 7'h5A, 8'h45); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        checks++; if (out_vld !== 1'b1 || out_bxn !== 12'd3563) begin
            errors++; $display("FAIL wrap_bxn vld=%0b bxn=%0d exp vld=1 bxn=3563", out_vld, out_bxn);
        end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        set_cand(1'b1, 7'h6A, 8'h21); tick();
        set_cand(1'b0, 7'h00, 8'h00); tick();
        checks++; if (out_vld !== 1'b1 || out_bxn !== 12'd2) begin
            errors++; $display("FAIL wrapped_bxn vld=%0b bxn=%0d exp vld=1 bxn=2", out_vld, out_bxn);
        end
        set_cand(1'b1, 7'h7E, 8'h44);
        for (int i = 0; i < 300; i++) tick();
        set_cand(1'b0, 7'h00, 8'h00);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat_hold got=%0d exp=255", drop_cnt); end
    endtask

    task automatic test_random();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cand_vld = ($urandom_range(0, 1) == 1);
            cand_pat = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) cand_key = {3'($urandom_range(5, 7)), 5'($urandom_range(0, 31))};
            else cand_key = {3'($urandom_range(0, 4)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 63) == 0) hit_thresh = 3'($urandom_range(0, 7));
            drift_dly = 4'($urandom_range(0, 4));
            dead_time = 4'($urandom_range(0, 4));
            out_rdy   = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
            checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL rnd_vld i=%0d got=%0b exp=%0b", i, out_vld, m_vld); end
            checks++; if (out_pat !== m_pat) begin errors++; $display("FAIL rnd_pat i=%0d got=%h exp=%h", i, out_pat, m_pat); end
            checks++; if (out_hs !== m_hs) begin errors++; $display("FAIL rnd_hs i=%0d got=%h exp=%h", i, out_hs, m_hs); end
            checks++; if (int'(out_bxn) != m_obxn) begin errors++; $display("FAIL rnd_bxn i=%0d got=%0d exp=%0d", i, out_bxn, m_obxn); end
            checks++; if (int'(drop_cnt) != m_drop) begin errors++; $display("FAIL rnd_drop i=%0d got=%0d exp=%0d", i, drop_cnt, m_drop); end
            checks++; if (err_cfeb !== m_err) begin errors++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, err_cfeb, m_err); end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replace();
        test_reject();
        test_stall();
        test_drift0_reset();
        test_bx_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
